// File: rtl/cam_search_sequencer_if.sv
// Search request / result handshake bundle for cam_search_sequencer.
//   req_valid/req_ready/req_key : search request from the requester.
//   rsp_valid/rsp_ready         : result handshake back to the requester.
//   rsp_hit/rsp_idx/rsp_vec     : result payload (any hit, lowest hit row, match vector).
// master = requester side, slave = sequencer side.
interface cam_search_sequencer_if #(
    parameter int ROWS  = 8,
    parameter int KEY_W = 16,
    parameter int IDX_W = $clog2(ROWS)
);
    logic             req_valid;
    logic             req_ready;
    logic [KEY_W-1:0] req_key;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic [IDX_W-1:0] rsp_idx;
    logic [ROWS-1:0]  rsp_vec;

    modport master (
        output req_valid, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_vec
    );

    modport slave (
        input  req_valid, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_vec
    );
endinterface

// File: rtl/cam_search_sequencer.sv
// Sequences one CAM search: precharge, search-line evaluate, sense strobe A, guard gap,
// sense strobe B and result capture, then returns the priority-encoded match result.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset.
//   bus (slave)          : request/response handshake (see cam_search_sequencer_if).
//   pre_n                : match-line precharge, active-low.
//   sl_en, sl_drive      : search-line enable and data (latched key).
//   strobe_a, strobe_b   : sense clocks A and B.
//   ml_m                 : per-row M output, row i matches when ml_m[i] == 0.
// Optional feature (macro CAM_SEARCH_STATS_EN): adds saturating 16-bit counters
//   stat_search (response handshakes) and stat_hit (handshakes with a hit).
// All outputs are registered; they are computed from the next state.
module cam_search_sequencer #(
    parameter int ROWS     = 8,
    parameter int KEY_W    = 16,
    parameter int PRE_CYC  = 2,
    parameter int EVAL_CYC = 3,
    parameter int GAP_CYC  = 1,
    parameter int IDX_W    = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cam_search_sequencer_if.slave bus,
    output logic                 pre_n,
    output logic                 sl_en,
    output logic [KEY_W-1:0]     sl_drive,
    output logic                 strobe_a,
    output logic                 strobe_b,
    input  logic [ROWS-1:0]      ml_m
`ifdef CAM_SEARCH_STATS_EN
    ,
    output logic [15:0]          stat_search,
    output logic [15:0]          stat_hit
`endif
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StPre  = 3'd1;
    localparam logic [2:0] StEval = 3'd2;
    localparam logic [2:0] StStrbA = 3'd3;
    localparam logic [2:0] StGap  = 3'd4;
    localparam logic [2:0] StStrbB = 3'd5;
    localparam logic [2:0] StCapt = 3'd6;
    localparam logic [2:0] StResp = 3'd7;

    // One shared down-counter covers every multi-cycle phase.
    localparam int MAX_CYC = (PRE_CYC > EVAL_CYC) ?
                             ((PRE_CYC > GAP_CYC) ? PRE_CYC : GAP_CYC) :
                             ((EVAL_CYC > GAP_CYC) ? EVAL_CYC : GAP_CYC);
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] EVAL_LD = CNT_W'(EVAL_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             req_ready_q, rsp_valid_q, rsp_hit_q;
    logic [IDX_W-1:0] rsp_idx_q, hit_idx;
    logic [ROWS-1:0]  rsp_vec_q;
    logic             sl_en_d;
    logic             rsp_hs;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign bus.rsp_vec   = rsp_vec_q;

    assign rsp_hs = (state_q == StResp) && rsp_valid_q && bus.rsp_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    state_d = StPre;
                    cnt_d   = PRE_LD;
                    key_d   = bus.req_key;
                end
            end
            StPre: begin
                if (cnt_q == '0) begin
                    state_d = StEval;
                    cnt_d   = EVAL_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StEval: begin
                if (cnt_q == '0) state_d = StStrbA;
                else cnt_d = cnt_q - 1'b1;
            end
            StStrbA: begin
                state_d = (GAP_CYC == 0) ? StStrbB : StGap;
                cnt_d   = GAP_LD;
            end
            StGap: begin
                if (cnt_q == '0) state_d = StStrbB;
                else cnt_d = cnt_q - 1'b1;
            end
            StStrbB: state_d = StCapt;
            StCapt:  state_d = StResp;
            StResp:  if (rsp_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign sl_en_d = (state_d == StEval) || (state_d == StStrbA) ||
                     (state_d == StGap) || (state_d == StStrbB);

    // Lowest matching row wins: scan high to low so the last write is the lowest index.
    always_comb begin
        hit_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!ml_m[i]) hit_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            key_q       <= '0;
            req_ready_q <= 1'b1;
            pre_n       <= 1'b1;
            sl_en       <= 1'b0;
            sl_drive    <= '0;
            strobe_a    <= 1'b0;
            strobe_b    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_vec_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            req_ready_q <= (state_d == StIdle);
            pre_n       <= (state_d != StPre);
            sl_en       <= sl_en_d;
            sl_drive    <= sl_en_d ? key_d : '0;
            strobe_a    <= (state_d == StStrbA);
            strobe_b    <= (state_d == StStrbB);
            if (state_q == StCapt) begin
                rsp_valid_q <= 1'b1;
                rsp_vec_q   <= ~ml_m;
                rsp_hit_q   <= ~&ml_m;
                rsp_idx_q   <= hit_idx;
            end else if (rsp_hs) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

`ifdef CAM_SEARCH_STATS_EN
    logic [15:0] stat_search_q, stat_hit_q;

    assign stat_search = stat_search_q;
    assign stat_hit    = stat_hit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_search_q <= '0;
            stat_hit_q    <= '0;
        end else if (rsp_hs) begin
            if (stat_search_q != 16'hFFFF) stat_search_q <= stat_search_q + 16'd1;
            if (rsp_hit_q && (stat_hit_q != 16'hFFFF)) stat_hit_q <= stat_hit_q + 16'd1;
        end
    end
`endif

endmodule
